// File: rtl/ram_loader_pkg.sv
// Shared types for the RAM loader: default bus widths, the loader state encoding,
// and a helper that decides when the loader owns the bus.
package ram_loader_pkg;

  localparam int ADDR_W_DFLT = 4;
  localparam int DATA_W_DFLT = 8;

  typedef logic [ADDR_W_DFLT-1:0] addr_t;
  typedef logic [DATA_W_DFLT-1:0] byte_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WRITE,
    ST_VERIFY,
    ST_CHECK,
    ST_DONE
  } state_t;

  // The CPU may use the bus only while the loader is parked.
  function automatic logic is_busy(input state_t s);
    return !(s == ST_IDLE || s == ST_DONE);
  endfunction

endpackage

// File: rtl/ram_loader_byte_checksum.sv
// Running modulo-2**DATA_W byte sum; one instance tracks written bytes, one read-back bytes.
module byte_checksum #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              add_en,
  input  logic [DATA_W-1:0] in,
  output logic [DATA_W-1:0] sum
);

  // Carry out of the top bit is discarded on purpose: the sum wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum <= '0;
    end else if (clear) begin
      sum <= '0;
    end else if (add_en) begin
      sum <= sum + in;
    end
  end

endmodule

// File: rtl/ram_loader.sv
// Bus initiator that streams LOAD_LEN bytes into the shared RAM, reads them back,
// and flags a checksum mismatch between what was written and what was read.
module ram_loader
  import ram_loader_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DFLT,
  parameter int DATA_W   = DATA_W_DFLT,
  parameter int LOAD_LEN = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] mem_address,
  output logic              ri,
  output logic              ro,
  inout  wire  [DATA_W-1:0] data,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(LOAD_LEN - 1);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr, addr_nxt;
  logic [DATA_W-1:0] byte_q;
  logic [DATA_W-1:0] wsum, rsum;
  logic              sum_clr, wadd, radd, load_byte;
  logic              done_nxt, error_nxt;

  byte_checksum #(.DATA_W(DATA_W)) u_wsum (
    .clk    (clk),
    .rst    (rst),
    .clear  (sum_clr),
    .add_en (wadd),
    .in     (byte_q),
    .sum    (wsum)
  );

  byte_checksum #(.DATA_W(DATA_W)) u_rsum (
    .clk    (clk),
    .rst    (rst),
    .clear  (sum_clr),
    .add_en (radd),
    .in     (data),
    .sum    (rsum)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      addr   <= '0;
      byte_q <= '0;
      done   <= 1'b0;
      error  <= 1'b0;
    end else begin
      state <= state_nxt;
      addr  <= addr_nxt;
      done  <= done_nxt;
      error <= error_nxt;
      if (load_byte) begin
        byte_q <= in_data;
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    addr_nxt    = addr;
    done_nxt    = done;
    error_nxt   = error;
    sum_clr     = 1'b0;
    wadd        = 1'b0;
    radd        = 1'b0;
    load_byte   = 1'b0;
    in_ready    = 1'b0;
    ri          = 1'b0;
    ro          = 1'b0;
    mem_address = '0;
    unique case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_nxt = ST_LOAD;
          addr_nxt  = '0;
          sum_clr   = 1'b1;
          done_nxt  = 1'b0;
          error_nxt = 1'b0;
        end
      end
      ST_LOAD: begin
        in_ready    = 1'b1;
        mem_address = addr;
        if (in_valid) begin
          load_byte = 1'b1;
          state_nxt = ST_WRITE;
        end
      end
      ST_WRITE: begin
        ri          = 1'b1;
        mem_address = addr;
        wadd        = 1'b1;
        if (addr == LAST) begin
          addr_nxt  = '0;
          state_nxt = ST_VERIFY;
        end else begin
          addr_nxt  = addr + 1'b1;
          state_nxt = ST_LOAD;
        end
      end
      ST_VERIFY: begin
        ro          = 1'b1;
        mem_address = addr;
        radd        = 1'b1;
        if (addr == LAST) begin
          state_nxt = ST_CHECK;
        end else begin
          addr_nxt = addr + 1'b1;
        end
      end
      ST_CHECK: begin
        done_nxt  = 1'b1;
        error_nxt = (wsum != rsum);
        state_nxt = ST_DONE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign busy = is_busy(state);

  // Because ri decodes straight from state, an async reset releases the bus at once.
  assign data = ri ? byte_q : {DATA_W{1'bz}};

endmodule

// File: tb/tb_ram_loader.sv
// Bench: ram_loader plus a 16x8 RAM model on a pulled-up shared bus; scoreboard of
// expected writes and completions checked by an independent monitor.
module tb_ram_loader;

  localparam int ADDR_W   = 4;
  localparam int DATA_W   = 8;
  localparam int LOAD_LEN = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] mem_address;
  logic              ri;
  logic              ro;
  tri1  [DATA_W-1:0] data;
  logic              busy;
  logic              done;
  logic              error;

  logic [DATA_W-1:0] mem [LOAD_LEN];
  logic              flip7;
  logic [DATA_W-1:0] rd_val;

  int tests = 0;
  int fails = 0;

  typedef struct { logic [ADDR_W-1:0] a; logic [DATA_W-1:0] d; } wr_t;
  typedef struct { logic err; int lat; } dn_t;
  wr_t wq[$];
  dn_t dq[$];
  wr_t wexp;
  dn_t dexp;
  logic [ADDR_W-1:0] waddr;
  int   edges;
  logic done_q;

  always #5 clk = ~clk;

  ram_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LOAD_LEN(LOAD_LEN)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .mem_address (mem_address),
    .ri          (ri),
    .ro          (ro),
    .data        (data),
    .busy        (busy),
    .done        (done),
    .error       (error)
  );

  // RAM model; flip7 corrupts bit 0 of address 7 on read only.
  assign rd_val = (flip7 && mem_address == 4'd7) ? (mem[mem_address] ^ 8'h01) : mem[mem_address];
  assign data   = ro ? rd_val : 8'hzz;

  initial begin
    for (int i = 0; i < LOAD_LEN; i++) mem[i] = 8'h00;
    forever begin
      @(posedge clk);
      if (ri) mem[mem_address] <= data;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: bus invariants, write scoreboard, completion scoreboard.
  initial begin
    done_q = 1'b0;
    edges  = 0;
    forever begin
      @(negedge clk);
      #1;
      // The edge that samples start is edge 0.
      if (start && !busy) edges = -1;
      else edges++;
      if (ri && ro) begin
        fails++;
        $display("FAIL ri_ro_overlap ri=%0b ro=%0b required not both", ri, ro);
      end
      if (!ri && !ro && data !== 8'hFF) begin
        fails++;
        $display("FAIL bus_float data=%02h required=released(ff)", data);
      end
      if (ri) begin
        if (wq.size() == 0) begin
          fails++;
          $display("FAIL unexpected_write addr=%0d data=%02h required=no write", mem_address, data);
        end else begin
          wexp = wq.pop_front();
          check("write_addr", 32'(mem_address), 32'(wexp.a));
          check("write_data", 32'(data), 32'(wexp.d));
        end
      end
      if (done && !done_q) begin
        if (dq.size() == 0) begin
          fails++;
          $display("FAIL unexpected_done done=1 required=0");
        end else begin
          dexp = dq.pop_front();
          check("done_error", 32'(error), 32'(dexp.err));
          if (dexp.lat >= 0) check("done_latency", 32'(edges), 32'(dexp.lat));
        end
      end
      done_q = done;
    end
  end

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send(input logic [DATA_W-1:0] b, input int gap);
    int n;
    if (gap > 0) begin
      in_valid = 1'b0;
      repeat (gap) @(negedge clk);
    end
    in_valid = 1'b1;
    in_data  = b;
    wq.push_back('{a: waddr, d: b});
    waddr++;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      fails++;
      $display("FAIL handshake_timeout in_ready=%0b required=1", in_ready);
    end
    @(negedge clk);
  endtask

  task automatic load(input logic [DATA_W-1:0] b [LOAD_LEN], input int gap [LOAD_LEN],
                      input logic exp_err, input int lat);
    waddr = '0;
    dq.push_back('{err: exp_err, lat: lat});
    do_start();
    check("cleared_on_start", 32'({done, error}), 32'(2'b00));
    for (int i = 0; i < LOAD_LEN; i++) send(b[i], gap[i]);
    in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      fails++;
      $display("FAIL done_timeout done=%0b required=1", done);
    end
    @(negedge clk);
  endtask

  task automatic check_ram(input logic [DATA_W-1:0] b [LOAD_LEN]);
    for (int i = 0; i < LOAD_LEN; i++) check($sformatf("ram[%0d]", i), 32'(mem[i]), 32'(b[i]));
  endtask

  logic [DATA_W-1:0] pat [LOAD_LEN];
  int                gaps [LOAD_LEN];

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; flip7 = 1'b0; waddr = '0;
    for (int i = 0; i < LOAD_LEN; i++) gaps[i] = 0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_outputs", 32'({busy, done, error, in_ready, ri, ro, mem_address, data}),
          32'({6'b000000, 4'h0, 8'hFF}));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // 1: incrementing bytes, in_valid held high
    for (int i = 0; i < LOAD_LEN; i++) pat[i] = 8'(i);
    load(pat, gaps, 1'b0, 49);
    wait_done();
    check_ram(pat);

    // 2: all 0xFF, sums wrap to 0xF0
    for (int i = 0; i < LOAD_LEN; i++) pat[i] = 8'hFF;
    load(pat, gaps, 1'b0, 49);
    wait_done();
    check("wsum_wrap", 32'(dut.wsum), 32'h0F0);
    check("rsum_wrap", 32'(dut.rsum), 32'h0F0);
    check_ram(pat);

    // 3: in_valid drops between bytes
    pat[0] = 8'hA5; pat[1] = 8'h5A; pat[2] = 8'hC3;
    for (int i = 3; i < LOAD_LEN; i++) pat[i] = 8'(8'h30 + i);
    gaps[1] = 2; gaps[2] = 3;
    load(pat, gaps, 1'b0, -1);
    gaps[1] = 0; gaps[2] = 0;
    wait_done();
    check_ram(pat);

    // 4: corrupted read-back of address 7
    for (int i = 0; i < LOAD_LEN; i++) pat[i] = 8'(8'h80 + i);
    flip7 = 1'b1;
    load(pat, gaps, 1'b1, 49);
    wait_done();
    flip7 = 1'b0;
    check("done_error_level", 32'({done, error}), 32'(2'b11));

    // 5: reset while writing address 5
    waddr = '0;
    do_start();
    for (int i = 0; i < 6; i++) send(8'(8'h40 + i), 0);
    check("pre_reset_write5", 32'({ri, mem_address}), 32'({1'b1, 4'd5}));
    rst = 1'b1;
    #1;
    check("reset_midwrite", 32'({ri, busy, done, data}), 32'({3'b000, 8'hFF}));
    void'(wq.pop_back());
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 5; i++) check($sformatf("kept_ram[%0d]", i), 32'(mem[i]), 32'(8'h40 + i));
    check("ram5_untouched", 32'(mem[5]), 32'h85);

    // 6: start during VERIFY ignored; restart clears done/error
    for (int i = 0; i < LOAD_LEN; i++) pat[i] = 8'(8'h20 + i);
    flip7 = 1'b1;
    load(pat, gaps, 1'b1, 49);
    n = 0;
    while (!ro && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("reached_verify", 32'(ro), 32'(1'b1));
    do_start();
    check("start_ignored_busy", 32'(busy), 32'(1'b1));
    wait_done();
    flip7 = 1'b0;
    for (int i = 0; i < LOAD_LEN; i++) pat[i] = 8'(8'h60 + i);
    load(pat, gaps, 1'b0, 49);
    wait_done();
    check_ram(pat);

    check("write_queue_drained", 32'(wq.size()), 32'(0));
    check("done_queue_drained", 32'(dq.size()), 32'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog time=%0t required=finish earlier", $time);
    $fatal(1, "watchdog");
  end

endmodule
